// File: rtl/multiword_add_sequencer.sv
// Multi-word add/subtract controller that time-shares one external WIDTH-bit slice adder,
// walking the operands least-significant slice first and keeping the inter-slice carry.
module multiword_add_sequencer #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NSLICE = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH*NSLICE-1:0]   in_a,
  input  logic [WIDTH*NSLICE-1:0]   in_b,
  input  logic                      in_cin,
  input  logic                      in_sub,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH*NSLICE-1:0]   out_sum,
  output logic                      out_cout,
  output logic                      busy,
  output logic [WIDTH-1:0]          slice_a,
  output logic [WIDTH-1:0]          slice_b,
  output logic                      slice_cin,
  input  logic [WIDTH-1:0]          slice_sum,
  input  logic                      slice_cout
);

  localparam int unsigned OPW  = WIDTH * NSLICE;
  localparam int unsigned IdxW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NSLICE - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [OPW-1:0]  opa_q, opa_d;
  logic [OPW-1:0]  opb_q, opb_d;
  logic [OPW-1:0]  result_q, result_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    result_d  = result_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    slice_a   = '0;
    slice_b   = '0;
    slice_cin = 1'b0;

    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          // Subtract is A + ~B + 1, so the carry register doubles as the +1.
          opa_d   = in_a;
          opb_d   = in_sub ? ~in_b : in_b;
          carry_d = in_sub ? 1'b1 : in_cin;
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        busy      = 1'b1;
        slice_a   = opa_q[idx_q*WIDTH +: WIDTH];
        slice_b   = opb_q[idx_q*WIDTH +: WIDTH];
        slice_cin = carry_q;
        result_d[idx_q*WIDTH +: WIDTH] = slice_sum;
        carry_d   = slice_cout;
        if (idx_q == IdxLast) begin
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Result and carry persist after the handshake; out_valid alone qualifies them.
  assign out_sum  = result_q;
  assign out_cout = carry_q;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Directed, table-driven bench for multiword_add_sequencer with a behavioural slice adder.
module tb_multiword_add_sequencer;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned NSLICE = 4;
  localparam int unsigned OPW    = WIDTH * NSLICE;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [OPW-1:0]   in_a;
  logic [OPW-1:0]   in_b;
  logic             in_cin;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [OPW-1:0]   out_sum;
  logic             out_cout;
  logic             busy;
  logic [WIDTH-1:0] slice_a;
  logic [WIDTH-1:0] slice_b;
  logic             slice_cin;
  logic [WIDTH-1:0] slice_sum;
  logic             slice_cout;

  multiword_add_sequencer #(
    .WIDTH (WIDTH),
    .NSLICE(NSLICE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .busy      (busy),
    .slice_a   (slice_a),
    .slice_b   (slice_b),
    .slice_cin (slice_cin),
    .slice_sum (slice_sum),
    .slice_cout(slice_cout)
  );

  assign {slice_cout, slice_sum} = {1'b0, slice_a} + {1'b0, slice_b} + {8'd0, slice_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic reset_checks(input string pfx);
    chk({pfx, "_in_ready"}, 64'(in_ready), 64'd1);
    chk({pfx, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({pfx, "_busy"}, 64'(busy), 64'd0);
    chk({pfx, "_slice"}, 64'({slice_a, slice_b, slice_cin}), 64'd0);
    chk({pfx, "_out"}, 64'({out_cout, out_sum}), 64'd0);
  endtask

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] sum;
    logic        cout;
    logic [3:0]  cins;  // expected slice_cin per slice, bit i = slice i
  } vec_t;

  task automatic run_op(input vec_t v, input int id);
    logic [31:0] opb;
    logic [3:0]  cins;
    logic        slice_ok;
    int          n;
    opb = v.sub ? ~v.b : v.b;
    @(negedge clk);
    chk($sformatf("v%0d_idle_ready", id), 64'(in_ready), 64'd1);
    in_a = v.a; in_b = v.b; in_cin = v.cin; in_sub = v.sub;
    in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0; cins = '0; slice_ok = 1'b1;
    while (!out_valid && n < 20) begin
      if (n < 4) begin
        cins[n] = slice_cin;
        if (slice_a !== v.a[n*8 +: 8] || slice_b !== opb[n*8 +: 8]) slice_ok = 1'b0;
      end
      n++;
      @(negedge clk);
    end
    chk($sformatf("v%0d_latency", id), 64'(n), 64'd4);
    chk($sformatf("v%0d_slice_cin_seq", id), 64'(cins), 64'(v.cins));
    chk($sformatf("v%0d_slice_operands", id), 64'(slice_ok), 64'd1);
    chk($sformatf("v%0d_sum", id), 64'(out_sum), 64'(v.sum));
    chk($sformatf("v%0d_cout", id), 64'(out_cout), 64'(v.cout));
    out_ready = 1'b1;
    @(negedge clk);
    chk($sformatf("v%0d_valid_drop", id), 64'(out_valid), 64'd0);
    chk($sformatf("v%0d_ready_back", id), 64'(in_ready), 64'd1);
    out_ready = 1'b0;
  endtask

  vec_t        vecs[8];
  logic [32:0] res[2];
  int          n, nres, t1, t2;
  logic        got2, saw_valid;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
    out_ready = 1'b0;
    #12;
    reset_checks("por");
    @(negedge clk);
    rst_n = 1'b1;

    vecs[0] = '{a: 32'hFFFFFFFF, b: 32'h00000001, cin: 1'b0, sub: 1'b0,
                sum: 32'h00000000, cout: 1'b1, cins: 4'b1110};
    vecs[1] = '{a: 32'h12345678, b: 32'h0FEDCBA8, cin: 1'b1, sub: 1'b0,
                sum: 32'h22222221, cout: 1'b0, cins: 4'b1111};
    vecs[2] = '{a: 32'h00000005, b: 32'h00000007, cin: 1'b0, sub: 1'b1,
                sum: 32'hFFFFFFFE, cout: 1'b0, cins: 4'b0001};
    vecs[3] = '{a: 32'h00000007, b: 32'h00000005, cin: 1'b0, sub: 1'b1,
                sum: 32'h00000002, cout: 1'b1, cins: 4'b1111};
    vecs[4] = '{a: 32'h00000001, b: 32'h00000001, cin: 1'b0, sub: 1'b0,
                sum: 32'h00000002, cout: 1'b0, cins: 4'b0000};
    vecs[5] = '{a: 32'hFFFF0000, b: 32'h0000FFFF, cin: 1'b0, sub: 1'b0,
                sum: 32'hFFFFFFFF, cout: 1'b0, cins: 4'b0000};
    vecs[6] = '{a: 32'h00000010, b: 32'h00000010, cin: 1'b0, sub: 1'b1,
                sum: 32'h00000000, cout: 1'b1, cins: 4'b1111};
    vecs[7] = '{a: 32'h00000000, b: 32'h00000000, cin: 1'b1, sub: 1'b0,
                sum: 32'h00000001, cout: 1'b0, cins: 4'b0001};
    for (int i = 0; i < 8; i++) run_op(vecs[i], i);

    // Backpressure: result must hold while out_ready is low, new requests ignored.
    @(negedge clk);
    in_a = 32'h12345678; in_b = 32'h0FEDCBA8; in_cin = 1'b1; in_sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin n++; @(negedge clk); end
    chk("bp_valid_seen", 64'(out_valid), 64'd1);
    in_valid = 1'b1; in_a = 32'hDEADBEEF; in_b = 32'h0BADF00D;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp_hold_valid_%0d", i), 64'(out_valid), 64'd1);
      chk($sformatf("bp_hold_sum_%0d", i), 64'({out_cout, out_sum}), 64'h0_22222221);
      chk($sformatf("bp_in_ready_%0d", i), 64'(in_ready), 64'd0);
    end
    chk("bp_slice_idle_zero", 64'({slice_a, slice_b, slice_cin}), 64'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 64'(out_valid), 64'd0);
    chk("bp_release_ready", 64'(in_ready), 64'd1);
    chk("bp_sum_kept", 64'(out_sum), 64'h22222221);

    // Back-to-back: in_valid held high across two requests.
    @(negedge clk);
    in_a = 32'h00000001; in_b = 32'h00000001; in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
    t1 = cyc; t2 = 0; got2 = 1'b0; nres = 0;
    @(negedge clk);
    in_a = 32'hFFFF0000; in_b = 32'h0000FFFF;
    for (int i = 0; i < 40 && nres < 2; i++) begin
      if (in_ready && !got2) begin
        t2 = cyc; got2 = 1'b1;
      end else if (got2) begin
        in_valid = 1'b0;
      end
      if (out_valid) begin
        res[nres] = {out_cout, out_sum};
        nres++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("b2b_result_count", 64'(nres), 64'd2);
    chk("b2b_second_accept", 64'(got2), 64'd1);
    chk("b2b_accept_spacing", 64'(t2 - t1), 64'd6);
    chk("b2b_res0", 64'(res[0]), 64'h0_00000002);
    chk("b2b_res1", 64'(res[1]), 64'h0_FFFFFFFF);

    // Reset asserted mid-RUN aborts the operation.
    @(negedge clk);
    in_a = 32'hFFFFFFFF; in_b = 32'h00000001; in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("abort_busy_before", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    reset_checks("abort");
    @(negedge clk);
    rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    chk("abort_no_result", 64'(saw_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
